adc_capture: RTL and testbench
==============================

Name: adc_capture

Overview:
- Multi-channel, triggered, decimating sample-capture block. Successor to the single-channel per-clock probe sampler.
- Each accepted sample is a timestamp plus all channel values, captured in the same cycle. Samples go into an on-chip FIFO and are read out over a valid/ready port.
- Sits beside the emulator datapath, taking its time counter and signal buses. Feeds the readout/debug host interface.

Parameters:
- N_CH, 2, number of signed channels sampled together
- SIG_BITS, 8, width of each channel sample
- TIME_BITS, 32, width of timestamp
- DEPTH, 16, FIFO entries (power of two, >=2)
- DECIM_BITS, 8, width of decimation ratio
- CNT_BITS, 16, width of requested sample count

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset; asynchronous, active-low
- time_curr  in  TIME_BITS  current emulated time
- sig  in  N_CH*SIG_BITS  packed signed channels; channel k is bits [k*SIG_BITS +: SIG_BITS]
- in_valid  in  1  sig/time_curr valid this cycle
- arm  in  1  pulse: flush FIFO, clear status, enter ARMED
- trig  in  1  capture trigger (level sampled while ARMED)
- abort  in  1  pulse: return to IDLE
- decim  in  DECIM_BITS  keep one of every decim+1 valid inputs
- n_samp  in  CNT_BITS  samples to store per capture (0 means unbounded)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_time  out  TIME_BITS  head timestamp
- out_sig  out  N_CH*SIG_BITS  head channel samples
- state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3
- overflow  out  1  sticky: a strobe was dropped because the FIFO was full
- stored  out  CNT_BITS  samples pushed in current capture

Behaviour:
- Reset: state=IDLE; FIFO empty; out_valid=0; out_time=0; out_sig=0; overflow=0; stored=0; decimation counter=0.
- IDLE:
  - arm -> ARMED.
  - Other inputs ignored.
- ARMED:
  - trig=1 -> CAPTURE.
  - The decimation counter loads 0 on the transition, so the first in_valid in CAPTURE is a strobe.
- CAPTURE:
  - On each in_valid, strobe = (dcnt==0).
  - dcnt <= (dcnt==0) ? decim : dcnt-1. decim=0 means every valid input is a strobe.
  - A strobe pushes {time_curr, sig}, registered on that edge.
  - The entry is visible at out_* with out_valid=1 on the next cycle if the FIFO was empty (1-cycle latency, first-word-fall-through).
- Push with FIFO full and no pop in the same cycle: sample dropped, overflow<=1, stored not incremented.
- Push with FIFO full and a simultaneous pop (out_valid & out_ready): push accepted.
- stored increments on each accepted push.
- When n_samp!=0 and an accepted push makes stored==n_samp -> DONE in the same edge.
- DONE:
  - No pushes.
  - FIFO drains normally.
  - arm -> ARMED.
- arm in any state:
  - Flushes FIFO (out_valid=0 next cycle), clears overflow and stored, state=ARMED.
  - A push in the same cycle is discarded.
- abort in any state: state=IDLE; FIFO contents and status retained.
- abort and arm in the same cycle: abort wins.
- Pop: out_valid & out_ready advances head on that edge.
  - out_* must hold stable while out_valid=1 and out_ready=0.
  - Popping is allowed in every state.
- FIFO pointers wrap modulo DEPTH. Occupancy is tracked with a count register of width clog2(DEPTH)+1.
- trig outside ARMED has no effect. in_valid outside CAPTURE has no effect.
- rst_n assertion mid-capture: immediate return to reset values; no partial entry is visible.

Decomposition:
- Package adc_pkg holds:
  - state enum adc_state_t (IDLE, ARMED, CAPTURE, DONE);
  - localparam ENTRY_BITS = TIME_BITS + N_CH*SIG_BITS, expressed as a function of the parameters;
  - pack/unpack helper functions for the entry.
- One sub-module, adc_fifo: synchronous FWFT FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: clk, rst_n, push, din, full, pop, dout, empty, flush.
  - Implements the full+pop acceptance rule.
- Top level holds the FSM, decimation counter, stored counter and overflow.

Test Plan:
- Decimated capture: arm; trig; decim=2; n_samp=4; 12 consecutive in_valid with time_curr=100..111 -> FIFO holds times 100,103,106,109; state=DONE after the edge at time 109; overflow=0.
- Overflow: DEPTH=16; out_ready=0; decim=0; n_samp=0; 20 valid inputs -> 16 entries, overflow=1, stored=16; head time equals the first input.
- Full and pop together: FIFO full; simultaneous strobe with out_ready=1 -> push accepted, overflow stays 0, count stays 16.
- Backpressure: out_ready toggled 1/0 -> out_time/out_sig constant while stalled; entries emerge in push order with no duplicates.
- Re-arm and abort: during CAPTURE with 5 entries, pulse arm -> out_valid=0 next cycle, stored=0, state=ARMED. Separately, abort and arm in the same cycle -> state=IDLE.
- Async reset: drop rst_n mid-capture between clock edges -> all outputs reset immediately; state=IDLE.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and helpers for the adc_capture slice.
// - adc_state_t: capture FSM state encoding (visible on the 'state' port).
// - entry_bits(): width of one FIFO entry {timestamp, channels}.
// - pack/unpack helpers for the default configuration.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } adc_state_t;

  localparam int DEF_N_CH      = 2;
  localparam int DEF_SIG_BITS  = 8;
  localparam int DEF_TIME_BITS = 32;

  function automatic int entry_bits(int time_bits, int n_ch, int sig_bits);
    return time_bits + n_ch * sig_bits;
  endfunction

  localparam int ENTRY_BITS = entry_bits(DEF_TIME_BITS, DEF_N_CH, DEF_SIG_BITS);

  typedef logic [ENTRY_BITS-1:0] entry_t;

  // Timestamp occupies the upper bits so a raw entry sorts by time.
  function automatic entry_t pack_entry(logic [DEF_TIME_BITS-1:0] t,
                                        logic [DEF_N_CH*DEF_SIG_BITS-1:0] s);
    return {t, s};
  endfunction

  function automatic logic [DEF_TIME_BITS-1:0] unpack_time(entry_t e);
    return e[ENTRY_BITS-1 -: DEF_TIME_BITS];
  endfunction

  function automatic logic [DEF_N_CH*DEF_SIG_BITS-1:0] unpack_sig(entry_t e);
    return e[DEF_N_CH*DEF_SIG_BITS-1:0];
  endfunction

endpackage

// File: rtl/adc_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   push, din      write request / data
//   full           count == DEPTH
//   pop, dout      read request / head data (zero while empty)
//   empty          no entries
//   flush          drop all entries; overrides push/pop that cycle
// A push while full is accepted when a pop happens on the same edge.
module adc_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  input  logic             flush
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      count;
  logic             do_pop, do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  // Gating the head with empty makes out_* read zero after reset/flush
  // without needing to clear the storage array.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers are AW bits wide, so increment wraps modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adc_capture.sv
// Triggered, decimating multi-channel sample capture.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   time_curr, sig       timestamp and packed signed channels
//   in_valid             inputs valid this cycle
//   arm, trig, abort     control (arm: flush+ARMED, trig: start, abort: IDLE)
//   decim, n_samp        keep 1 of decim+1 inputs; stop after n_samp (0=never)
//   out_valid/out_ready  FIFO head handshake; out_time/out_sig head data
//   state, overflow      FSM state, sticky dropped-sample flag
//   stored               samples accepted in this capture
module adc_capture
  import adc_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int SIG_BITS   = 8,
  parameter int TIME_BITS  = 32,
  parameter int DEPTH      = 16,
  parameter int DECIM_BITS = 8,
  parameter int CNT_BITS   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [TIME_BITS-1:0]     time_curr,
  input  logic [N_CH*SIG_BITS-1:0] sig,
  input  logic                     in_valid,
  input  logic                     arm,
  input  logic                     trig,
  input  logic                     abort,
  input  logic [DECIM_BITS-1:0]    decim,
  input  logic [CNT_BITS-1:0]      n_samp,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TIME_BITS-1:0]     out_time,
  output logic [N_CH*SIG_BITS-1:0] out_sig,
  output logic [1:0]               state,
  output logic                     overflow,
  output logic [CNT_BITS-1:0]      stored
);

  localparam int EW = entry_bits(TIME_BITS, N_CH, SIG_BITS);

  adc_state_t            st;
  logic [DECIM_BITS-1:0] dcnt;
  logic                  strobe, push_req, accepted, pop_fire;
  logic                  fifo_full, fifo_empty, flush;
  logic [EW-1:0]         din, dout;
  logic [CNT_BITS-1:0]   stored_nxt;

  assign pop_fire = out_valid & out_ready;
  assign flush    = arm & ~abort;

  // A control pulse in the same cycle owns the FIFO: arm discards the
  // sample, abort keeps contents untouched.
  assign strobe   = (st == CAPTURE) & in_valid & (dcnt == '0);
  assign push_req = strobe & ~arm & ~abort;
  assign accepted = push_req & (~fifo_full | pop_fire);

  assign stored_nxt = stored + 1'b1;
  assign din        = {time_curr, sig};

  adc_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .din   (din),
    .full  (fifo_full),
    .pop   (out_ready),
    .dout  (dout),
    .empty (fifo_empty),
    .flush (flush)
  );

  assign out_valid = ~fifo_empty;
  assign out_time  = dout[EW-1 -: TIME_BITS];
  assign out_sig   = dout[N_CH*SIG_BITS-1:0];
  assign state     = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      dcnt     <= '0;
      overflow <= 1'b0;
      stored   <= '0;
    end else if (abort) begin
      st <= IDLE;
    end else if (arm) begin
      st       <= ARMED;
      dcnt     <= '0;
      overflow <= 1'b0;
      stored   <= '0;
    end else begin
      case (st)
        ARMED: begin
          if (trig) begin
            st   <= CAPTURE;
            dcnt <= '0;
          end
        end
        CAPTURE: begin
          if (in_valid) dcnt <= (dcnt == '0) ? decim : dcnt - 1'b1;
          if (accepted) begin
            stored <= stored_nxt;
            if (n_samp != '0 && stored_nxt == n_samp) st <= DONE;
          end else if (push_req) begin
            overflow <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture.sv
// Directed self-checking bench for adc_capture (default parameters).
module tb_adc_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] time_curr;
  logic [15:0] sig;
  logic        in_valid, arm, trig, abort, out_ready;
  logic [7:0]  decim;
  logic [15:0] n_samp;
  logic        out_valid;
  logic [31:0] out_time;
  logic [15:0] out_sig;
  logic [1:0]  state;
  logic        overflow;
  logic [15:0] stored;

  int total = 0;
  int bad   = 0;

  adc_capture dut (
    .clk(clk), .rst_n(rst_n), .time_curr(time_curr), .sig(sig),
    .in_valid(in_valid), .arm(arm), .trig(trig), .abort(abort),
    .decim(decim), .n_samp(n_samp), .out_valid(out_valid),
    .out_ready(out_ready), .out_time(out_time), .out_sig(out_sig),
    .state(state), .overflow(overflow), .stored(stored)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk_sig(int t);
    logic [7:0] a, b;
    a = 8'(t);
    b = 8'(-t);
    return {b, a};
  endfunction

  // arm pulse then trig pulse; leaves the DUT in CAPTURE
  task automatic start_capture(input logic [7:0] d, input logic [15:0] n);
    decim = d; n_samp = n;
    arm = 1'b1; tick(); arm = 1'b0;
    trig = 1'b1; tick(); trig = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_time !== 32'd0 || out_sig !== 16'd0) begin bad++; $display("FAIL reset_data got=%0d/%h exp=0/0", out_time, out_sig); end
    total++; if (overflow !== 1'b0 || stored !== 16'd0) begin bad++; $display("FAIL reset_status got=%b/%0d exp=0/0", overflow, stored); end
  endtask

  task automatic test_decim();
    int exp_t [4] = '{100, 103, 106, 109};
    decim = 8'd2; n_samp = 16'd4;
    arm = 1'b1; tick(); arm = 1'b0;
    total++; if (state !== 2'd1) begin bad++; $display("FAIL decim_armed got=%0d exp=1", state); end
    trig = 1'b1; tick(); trig = 1'b0;
    total++; if (state !== 2'd2) begin bad++; $display("FAIL decim_capture got=%0d exp=2", state); end
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; time_curr = 32'(100 + i); sig = mk_sig(100 + i);
      tick();
      if (i == 9) begin
        total++; if (state !== 2'd3) begin bad++; $display("FAIL decim_done_edge got=%0d exp=3", state); end
      end
    end
    in_valid = 1'b0;
    total++; if (stored !== 16'd4 || overflow !== 1'b0) begin bad++; $display("FAIL decim_status got=%0d/%b exp=4/0", stored, overflow); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_time !== 32'(exp_t[k]) || out_sig !== mk_sig(exp_t[k])) begin
        bad++; $display("FAIL decim_entry%0d got=%b/%0d/%h exp=1/%0d/%h", k, out_valid, out_time, out_sig, exp_t[k], mk_sig(exp_t[k]));
      end
      tick();
    end
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL decim_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    start_capture(8'd0, 16'd0);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; time_curr = 32'(200 + i); sig = mk_sig(200 + i);
      tick();
    end
    in_valid = 1'b0;
    total++; if (stored !== 16'd16) begin bad++; $display("FAIL ovf_stored got=%0d exp=16", stored); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    total++; if (out_time !== 32'd200 || state !== 2'd2) begin bad++; $display("FAIL ovf_head got=%0d/%0d exp=200/2", out_time, state); end
  endtask

  task automatic test_full_pop();
    int pops, last;
    out_ready = 1'b0;
    start_capture(8'd0, 16'd0);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; time_curr = 32'(300 + i); sig = mk_sig(300 + i);
      tick();
    end
    total++; if (overflow !== 1'b0 || stored !== 16'd16) begin bad++; $display("FAIL fp_fill got=%b/%0d exp=0/16", overflow, stored); end
    time_curr = 32'd316; sig = mk_sig(316); out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (overflow !== 1'b0 || stored !== 16'd17 || out_time !== 32'd301) begin
      bad++; $display("FAIL fp_accept got=%b/%0d/%0d exp=0/17/301", overflow, stored, out_time);
    end
    pops = 0; last = 0;
    for (int c = 0; c < 40 && out_valid; c++) begin
      last = int'(out_time); pops++;
      tick();
    end
    out_ready = 1'b0;
    total++; if (pops != 16 || last != 316) begin bad++; $display("FAIL fp_count got=%0d/%0d exp=16/316", pops, last); end
  endtask

  task automatic test_backpressure();
    int idx;
    out_ready = 1'b0;
    start_capture(8'd0, 16'd0);
    in_valid = 1'b1; time_curr = 32'd400; sig = mk_sig(400);
    tick();
    total++; if (out_valid !== 1'b1 || out_time !== 32'd400) begin bad++; $display("FAIL bp_latency got=%b/%0d exp=1/400", out_valid, out_time); end
    for (int i = 1; i < 4; i++) begin
      time_curr = 32'(400 + i); sig = mk_sig(400 + i);
      tick();
    end
    in_valid = 1'b0;
    idx = 0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      total++;
      if (out_valid !== 1'b1 || out_time !== 32'(400 + idx) || out_sig !== mk_sig(400 + idx)) begin
        bad++; $display("FAIL bp_entry got=%b/%0d/%h exp=1/%0d/%h", out_valid, out_time, out_sig, 400 + idx, mk_sig(400 + idx));
      end
      out_ready = c[0];
      tick();
      if (out_ready) idx++;
    end
    out_ready = 1'b0;
    total++; if (idx != 4 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_end got=%0d/%b exp=4/0", idx, out_valid); end
  endtask

  task automatic test_rearm_abort();
    out_ready = 1'b0;
    start_capture(8'd0, 16'd0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; time_curr = 32'(500 + i); sig = mk_sig(500 + i);
      tick();
    end
    total++; if (stored !== 16'd5) begin bad++; $display("FAIL rearm_pre got=%0d exp=5", stored); end
    arm = 1'b1; tick(); arm = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || stored !== 16'd0 || state !== 2'd1) begin
      bad++; $display("FAIL rearm got=%b/%0d/%0d exp=0/0/1", out_valid, stored, state);
    end
    trig = 1'b1; tick(); trig = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; time_curr = 32'(600 + i); sig = mk_sig(600 + i);
      tick();
    end
    in_valid = 1'b0;
    abort = 1'b1; arm = 1'b1; tick(); abort = 1'b0; arm = 1'b0;
    total++; if (state !== 2'd0 || stored !== 16'd2 || out_valid !== 1'b1 || out_time !== 32'd600) begin
      bad++; $display("FAIL abort_arm got=%0d/%0d/%b/%0d exp=0/2/1/600", state, stored, out_valid, out_time);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    start_capture(8'd0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; time_curr = 32'(700 + i); sig = mk_sig(700 + i);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (state !== 2'd0 || out_valid !== 1'b0 || out_time !== 32'd0 || out_sig !== 16'd0 || stored !== 16'd0 || overflow !== 1'b0) begin
      bad++; $display("FAIL async_reset got=%0d/%b/%0d/%h/%0d/%b exp=0/0/0/0/0/0", state, out_valid, out_time, out_sig, stored, overflow);
    end
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    total++; if (state !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL post_reset got=%0d/%b exp=0/0", state, out_valid); end
  endtask

  initial begin
    rst_n = 1'b0; time_curr = '0; sig = '0; in_valid = 1'b0;
    arm = 1'b0; trig = 1'b0; abort = 1'b0; out_ready = 1'b0;
    decim = '0; n_samp = '0;
    #23 rst_n = 1'b1;
    tick();
    test_reset();
    test_decim();
    test_overflow();
    test_full_pop();
    test_backpressure();
    test_rearm_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
